key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_pkg.sv | 23 ++
 rtl/key_debounce_ch.sv | 136 +++++++++++++
 rtl/key_debounce.sv | 46 ++++
 tb/tb_key_debounce.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debouncer: channel FSM encoding and ms-to-cycles helper.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPressDeb = 2'd1,
    StHeld     = 2'd2,
    StRelDeb   = 2'd3
  } deb_state_e;

  // Cycles in a window of ms milliseconds at clk_fre Hz.
  function automatic int unsigned ms_to_cyc(input int unsigned clk_fre, input int unsigned ms);
    return clk_fre / 1000 * ms;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// Single key channel: 2-flop synchronizer, debounce FSM, hold/repeat counters.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEB_CNT  = 4,
  parameter int unsigned LONG_CNT = 20,
  parameter int unsigned REP_CNT  = 5,
  parameter int unsigned CW       = 6
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_repeat,
  output logic key_release
);

  localparam logic [CW-1:0] DebLast  = CW'(DEB_CNT - 1);
  localparam logic [CW-1:0] LongCnt  = CW'(LONG_CNT);
  localparam logic [CW-1:0] LongLast = CW'(LONG_CNT - 1);
  localparam logic [CW-1:0] RepLast  = CW'(REP_CNT - 1);

  logic       sync1_q, sync2_q;
  deb_state_e state_q, state_d;
  logic [CW-1:0] deb_q, deb_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [CW-1:0] rep_q, rep_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic repeat_q, repeat_d;
  logic release_q, release_d;

  // Synchronize the raw pin; reset value 1 means released.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      deb_q     <= '0;
      hold_q    <= '0;
      rep_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      repeat_q  <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
      level_q   <= level_d;
      press_q   <= press_d;
      repeat_q  <= repeat_d;
      release_q <= release_d;
    end
  end

  // Next-state logic; sync2_q low means the key is pressed.
  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    level_d   = level_q;
    press_d   = 1'b0;
    repeat_d  = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!sync2_q) begin
          state_d = StPressDeb;
          deb_d   = '0;
        end
      end
      StPressDeb: begin
        if (sync2_q) begin
          state_d = StIdle;
        end else if (deb_q == DebLast) begin
          state_d = StHeld;
          press_d = 1'b1;
          level_d = 1'b1;
          hold_d  = '0;
          rep_d   = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      StHeld: begin
        if (sync2_q) begin
          state_d = StRelDeb;
          deb_d   = '0;
        end else if (hold_q != LongCnt) begin
          // Hold counter saturates at LONG_CNT; the repeat counter takes over from there.
          hold_d = hold_q + 1'b1;
          if (hold_q == LongLast) begin
            repeat_d = 1'b1;
          end
        end else if (rep_q == RepLast) begin
          rep_d    = '0;
          repeat_d = 1'b1;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
      StRelDeb: begin
        // Hold/repeat counters are left untouched so a release glitch resumes the hold.
        if (!sync2_q) begin
          state_d = StHeld;
        end else if (deb_q == DebLast) begin
          state_d   = StIdle;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign key_state   = level_q;
  assign key_press   = press_q;
  assign key_repeat  = repeat_q;
  assign key_release = release_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-channel key debouncer with press/repeat/release pulses.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter logic [25:0] CLK_FRE = 26'd27_000_000,
  parameter int unsigned KEY_N   = 3,
  parameter int unsigned DEB_MS  = 20,
  parameter int unsigned LONG_MS = 1000,
  parameter int unsigned REP_MS  = 200
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [KEY_N-1:0] key_in,
  output logic [KEY_N-1:0] key_state,
  output logic [KEY_N-1:0] key_press,
  output logic [KEY_N-1:0] key_repeat,
  output logic [KEY_N-1:0] key_release,
  output logic [KEY_N-1:0] key_act
);

  localparam int unsigned DEB_CNT  = ms_to_cyc(32'(CLK_FRE), DEB_MS);
  localparam int unsigned LONG_CNT = ms_to_cyc(32'(CLK_FRE), LONG_MS);
  localparam int unsigned REP_CNT  = ms_to_cyc(32'(CLK_FRE), REP_MS);
  localparam int unsigned CW       = $clog2(max3(DEB_CNT, LONG_CNT, REP_CNT)) + 1;

  for (genvar i = 0; i < KEY_N; i++) begin : g_ch
    key_debounce_ch #(
      .DEB_CNT  (DEB_CNT),
      .LONG_CNT (LONG_CNT),
      .REP_CNT  (REP_CNT),
      .CW       (CW)
    ) u_ch (
      .clk         (clk),
      .rstn        (rstn),
      .key_in      (key_in[i]),
      .key_state   (key_state[i]),
      .key_press   (key_press[i]),
      .key_repeat  (key_repeat[i]),
      .key_release (key_release[i])
    );
  end

  // Both inputs are registered, so key_act has no path from key_in.
  assign key_act = key_press | key_repeat;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with a pulse scoreboard checked every cycle.
module tb_key_debounce;

  localparam int KEY_N = 3;
  localparam int KP = 0;
  localparam int KR = 1;
  localparam int KL = 2;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [KEY_N-1:0] key_in = '1;
  logic [KEY_N-1:0] key_state, key_press, key_repeat, key_release, key_act;

  int  cyc = 0;
  int  passed = 0;
  int  total = 0;
  ev_t sb[$];

  key_debounce #(
    .CLK_FRE (26'd1000),
    .KEY_N   (KEY_N),
    .DEB_MS  (4),
    .LONG_MS (20),
    .REP_MS  (5)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .key_in      (key_in),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_repeat  (key_repeat),
    .key_release (key_release),
    .key_act     (key_act)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int at, input int kind, input int ch);
    ev_t e;
    e.cyc  = at;
    e.kind = kind;
    e.ch   = ch;
    sb.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [KEY_N-1:0] obs,
                     input logic [KEY_N-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cyc=%0d observed=%b expected=%b", name, cyc, obs, exp);
  endtask

  // Scoreboard: every cycle, pulses due now must be exactly what the DUT shows.
  initial begin
    forever begin
      logic [KEY_N-1:0] ep, er, el;
      @(negedge clk);
      ep = '0;
      er = '0;
      el = '0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc <= cyc) begin
          if (sb[i].kind == KP) ep[sb[i].ch] = 1'b1;
          else if (sb[i].kind == KR) er[sb[i].ch] = 1'b1;
          else el[sb[i].ch] = 1'b1;
          sb.delete(i);
        end
      end
      chk("press", key_press, ep);
      chk("repeat", key_repeat, er);
      chk("release", key_release, el);
      chk("act", key_act, ep | er);
    end
  end

  initial begin
    int c;
    // Reset state
    rstn   = 1'b0;
    key_in = '1;
    wait_n(3);
    chk("rst_state", key_state, 3'b000);
    rstn = 1'b1;
    wait_n(4);

    // Clean press and release on key 0
    c = cyc;
    key_in[0] = 1'b0;
    push(c + 7, KP, 0);
    wait_n(6);
    chk("clean_state_pre", key_state, 3'b000);
    wait_n(1);
    chk("clean_state_set", key_state, 3'b001);
    wait_n(3);
    key_in[0] = 1'b1;
    push(c + 17, KL, 0);
    wait_n(6);
    chk("rel_state_pre", key_state, 3'b001);
    wait_n(1);
    chk("rel_state_clr", key_state, 3'b000);
    wait_n(5);

    // Release glitch while held: no release, no second press
    c = cyc;
    key_in[0] = 1'b0;
    push(c + 7, KP, 0);
    wait_n(12);
    key_in[0] = 1'b1;
    wait_n(2);
    key_in[0] = 1'b0;
    wait_n(4);
    chk("glitch_state", key_state, 3'b001);
    key_in[0] = 1'b1;
    push(c + 25, KL, 0);
    wait_n(7);
    chk("glitch_rel_state", key_state, 3'b000);
    wait_n(5);

    // Bouncing key 1 never debounces
    for (int i = 0; i < 5; i++) begin
      key_in[1] = 1'b0;
      wait_n(2);
      key_in[1] = 1'b1;
      wait_n(1);
    end
    wait_n(8);
    chk("bounce_state", key_state, 3'b000);

    // Long hold on key 2 with auto-repeat
    c = cyc;
    key_in[2] = 1'b0;
    push(c + 7, KP, 2);
    push(c + 27, KR, 2);
    push(c + 32, KR, 2);
    push(c + 37, KR, 2);
    wait_n(20);
    chk("long_state", key_state, 3'b100);
    wait_n(18);
    key_in[2] = 1'b1;
    push(c + 45, KL, 2);
    wait_n(10);
    chk("long_rel_state", key_state, 3'b000);

    // Simultaneous press on keys 0 and 1
    c = cyc;
    key_in[1:0] = 2'b00;
    push(c + 7, KP, 0);
    push(c + 7, KP, 1);
    wait_n(8);
    chk("simul_state", key_state, 3'b011);
    wait_n(2);
    key_in[1:0] = 2'b11;
    push(c + 17, KL, 0);
    push(c + 17, KL, 1);
    wait_n(7);
    chk("simul_rel_state", key_state, 3'b000);
    wait_n(5);

    // Reset mid-hold: no release, fresh press after reset
    c = cyc;
    key_in[0] = 1'b0;
    push(c + 7, KP, 0);
    wait_n(15);
    rstn = 1'b0;
    wait_n(1);
    chk("midrst_state", key_state, 3'b000);
    chk("midrst_press", key_press, 3'b000);
    wait_n(2);
    rstn = 1'b1;
    push(c + 25, KP, 0);
    wait_n(7);
    chk("repress_state", key_state, 3'b001);
    wait_n(3);
    key_in[0] = 1'b1;
    push(c + 35, KL, 0);
    wait_n(10);
    chk("final_state", key_state, 3'b000);
    wait_n(5);

    total++;
    assert (sb.size() == 0) passed++;
    else $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
